// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: FSM encodings, word geometry, error codes and request payload.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              r;
    logic              w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core-to-memory port: request fields from the core, ready/err/rdata response from memory.
interface mem_responder_if;
  import mem_pkg::*;

  logic              r;
  logic              w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;

  modport master (output r, w, addr, wdata, input rdata, ready, err);
  modport slave  (input r, w, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_responder_latency_counter.sv
// Loadable down-counter timing the WAIT phase; done_c flags the last wait cycle.
module latency_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory with a fixed-latency ready/err handshake, one request in flight at a time.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(WORD_BYTES * DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  mem_req_t          req_q,   req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q,   err_d;

  mem_req_t          live_c;
  mem_req_t          cur_c;
  logic [IDX_W-1:0]  idx_c;
  logic              bad_c;
  logic              enter_resp_c;
  logic              mem_we_c;
  logic              cnt_load_c;
  logic              cnt_done_c;

  latency_counter u_lat (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load_c),
    .load_val (CNT_W'(LATENCY)),
    .done_c   (cnt_done_c)
  );

  // With zero latency the access happens on the capture edge, so it must use the live request.
  always_comb begin
    live_c = '{r: bus.r, w: bus.w, addr: bus.addr, wdata: bus.wdata};
    cur_c  = (state_q == IDLE) ? live_c : req_q;
    idx_c  = cur_c.addr[IDX_W+1:2];
    bad_c  = (cur_c.r && cur_c.w) || (cur_c.addr[1:0] != 2'b00) || (cur_c.addr >= ADDR_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    ready_d      = 1'b0;
    err_d        = ERR_NONE;
    cnt_load_c   = 1'b0;
    enter_resp_c = 1'b0;
    mem_we_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.r || bus.w) begin
          req_d = live_c;
          if (ZERO_LAT) begin
            enter_resp_c = 1'b1;
          end else begin
            state_d    = WAIT;
            cnt_load_c = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_done_c) begin
          enter_resp_c = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp_c) begin
      state_d = RESP;
      ready_d = 1'b1;
      if (bad_c) begin
        err_d = ERR_SET;
      end else if (cur_c.r) begin
        rdata_d = mem[idx_c];
      end else begin
        mem_we_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; a write is committed only outside reset.
  always_ff @(posedge clk) begin
    if (mem_we_c && reset) begin
      mem[idx_c] <= cur_c.wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule
